// File: rtl/rv_pkg.sv
// Shared RISC-V write-back types: data/address widths, register typedefs and
// the write-port arbiter state encoding.
package rv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xdata_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   typedef enum logic {
      PRI_MEM = 1'b0,
      PRI_ALU = 1'b1
   } arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared
// the cycle after commit. Optional forwarding outputs under WB_BYPASS_EN.
module wb_scoreboard #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = rv_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rd,
   input  logic          commit_en,
   input  logic [AW-1:0] commit_addr,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
`ifdef WB_BYPASS_EN
   output logic          rs1_fwd_valid,
   output logic          rs2_fwd_valid,
`endif
   output logic          rs1_busy,
   output logic          rs2_busy
);
   import rv_pkg::*;

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_set_en;
   logic            w_rs1_hit;
   logic            w_rs2_hit;

   assign w_set_en = issue_valid && (issue_rd != AW'(ZERO_REG));

   // Clear first, then set, so a younger issue overrides a same-cycle retire.
   always_comb begin
      w_busy_nxt = r_busy;
      if (commit_en) begin
         w_busy_nxt[commit_addr] = 1'b0;
      end
      if (w_set_en) begin
         w_busy_nxt[issue_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign w_rs1_hit = commit_en && (commit_addr == rs1) && (rs1 != AW'(ZERO_REG));
   assign w_rs2_hit = commit_en && (commit_addr == rs2) && (rs2 != AW'(ZERO_REG));

`ifdef WB_BYPASS_EN
   assign rs1_fwd_valid = w_rs1_hit;
   assign rs2_fwd_valid = w_rs2_hit;
   assign rs1_busy      = r_busy[rs1];
   assign rs2_busy      = r_busy[rs2];
`else
   assign rs1_busy      = r_busy[rs1] | w_rs1_hit;
   assign rs2_busy      = r_busy[rs2] | w_rs2_hit;
`endif

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and load pipes,
// with starvation-driven priority flip. Forwarding ports under WB_BYPASS_EN.
module regfile_wb_scheduler #(
   parameter int unsigned XLEN         = rv_pkg::XLEN,
   parameter int unsigned NREG         = 32,
   parameter int unsigned AW           = rv_pkg::AW,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [AW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
`ifdef WB_BYPASS_EN
   output logic            rs1_fwd_valid,
   output logic [XLEN-1:0] rs1_fwd_data,
   output logic            rs2_fwd_valid,
   output logic [XLEN-1:0] rs2_fwd_data,
`endif
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata
);
   import rv_pkg::*;

   localparam int unsigned CW    = 4;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   arb_state_e      r_state;
   arb_state_e      w_state_nxt;
   logic [CW-1:0]   r_starve;
   logic [CW-1:0]   w_starve_nxt;
   logic            w_alu_req;
   logic            w_mem_req;
   logic            w_alu_grant;
   logic            w_mem_grant;
   logic            r_we;
   logic [AW-1:0]   r_waddr;
   logic [XLEN-1:0] r_wdata;

   // x0 writes never contend for the port; reset blocks every handshake.
   assign w_alu_req   = !rst && alu_valid && (alu_rd != AW'(ZERO_REG));
   assign w_mem_req   = !rst && mem_valid && (mem_rd != AW'(ZERO_REG));
   assign w_alu_grant = w_alu_req && (!w_mem_req || (r_state == PRI_ALU));
   assign w_mem_grant = w_mem_req && (!w_alu_req || (r_state == PRI_MEM));

   assign alu_ready = !rst && alu_valid && ((alu_rd == AW'(ZERO_REG)) || w_alu_grant);
   assign mem_ready = !rst && mem_valid && ((mem_rd == AW'(ZERO_REG)) || w_mem_grant);

   // Priority flips as soon as the counter will reach the limit, so the
   // ALU wins the very next conflict.
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      if (w_alu_grant) begin
         w_starve_nxt = '0;
      end else if (w_alu_req && (r_starve != LIMIT)) begin
         w_starve_nxt = r_starve + CW'(1);
      end
      case (r_state)
         PRI_MEM: if (w_starve_nxt == LIMIT) w_state_nxt = PRI_ALU;
         PRI_ALU: if (w_alu_grant)           w_state_nxt = PRI_MEM;
         default:                            w_state_nxt = PRI_MEM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= PRI_MEM;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_alu_grant || w_mem_grant;
         if (w_mem_grant) begin
            r_waddr <= mem_rd;
            r_wdata <= mem_data;
         end else if (w_alu_grant) begin
            r_waddr <= alu_rd;
            r_wdata <= alu_data;
         end
      end
   end

   assign rf_we    = r_we;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;

   wb_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .commit_en     (r_we),
      .commit_addr   (r_waddr),
      .rs1           (rs1),
      .rs2           (rs2),
`ifdef WB_BYPASS_EN
      .rs1_fwd_valid (rs1_fwd_valid),
      .rs2_fwd_valid (rs2_fwd_valid),
`endif
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy)
   );

`ifdef WB_BYPASS_EN
   assign rs1_fwd_data = r_wdata;
   assign rs2_fwd_data = r_wdata;
`endif

endmodule
